// File: rtl/bus_xfer_ctrl.sv
// rtl/bus_xfer_ctrl.sv - direction/enable sequencer for single-byte transfers through a bus transceiver
module bus_xfer_ctrl #(
    parameter int TURN_CYCLES   = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       _reset,
    input  logic       req,
    input  logic       wr,
    input  logic [7:0] wdata,
    input  logic [7:0] a_in,
    output logic [7:0] a_drive,
    output logic       a_drive_en,
    output logic       dir,
    output logic       _oe,
    output logic       busy,
    output logic       ack,
    output logic [7:0] rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TURN    = 3'd1,
        SETTLE  = 3'd2,
        DONE    = 3'd3,
        RELEASE = 3'd4
    } xferState_t;

    // The counter is loaded with (cycles - 1) and a phase ends on the cycle it reads zero.
    localparam logic [7:0] TurnLoad   = 8'(TURN_CYCLES - 1);
    localparam logic [7:0] SettleLoad = 8'(SETTLE_CYCLES - 1);

    xferState_t state;
    xferState_t nextState;
    logic [7:0] cycleCnt;
    logic       dirReg;        // latched wr; doubles as the transceiver direction
    logic [7:0] latchedWdata;
    logic [7:0] rdataReg;

    logic accept;
    logic dirChange;
    logic cntZero;
    logic enterDone;

    assign accept    = (state == IDLE) && req;
    // Compared against the direction currently driven, so reset (dir=0) counts as the prior direction.
    assign dirChange = (wr != dirReg);
    assign cntZero   = (cycleCnt == 8'd0);
    assign enterDone = (state == SETTLE) && cntZero;

    // State register.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state: IDLE -> TURN -> SETTLE -> DONE -> RELEASE -> IDLE, req only looked at in IDLE.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (req)     nextState = TURN;
            TURN:    if (cntZero) nextState = SETTLE;
            SETTLE:  if (cntZero) nextState = DONE;
            DONE:                 nextState = RELEASE;
            RELEASE:              nextState = IDLE;
            default:              nextState = IDLE;
        endcase
    end

    // Phase counter: long turnaround only when the direction actually flips.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            cycleCnt <= 8'd0;
        end else begin
            case (state)
                IDLE:    cycleCnt <= (req && dirChange) ? TurnLoad : 8'd0;
                TURN:    cycleCnt <= cntZero ? SettleLoad : cycleCnt - 8'd1;
                SETTLE:  cycleCnt <= cntZero ? 8'd0 : cycleCnt - 8'd1;
                default: cycleCnt <= 8'd0;
            endcase
        end
    end

    // Capture the request at acceptance; later wr/wdata changes cannot reach the transfer.
    // dir only moves here, in IDLE, where _oe is 1 now and stays 1 through TURN.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            dirReg       <= 1'b0;
            latchedWdata <= 8'd0;
        end else if (accept) begin
            dirReg       <= wr;
            latchedWdata <= wdata;
        end
    end

    // Read data is taken from the A side on the edge that enters DONE.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            rdataReg <= 8'd0;
        end else if (enterDone && !dirReg) begin
            rdataReg <= a_in;
        end
    end

    // Outputs per state; the A-side driver follows dir, so it can never be on while dir=0.
    always_comb begin
        _oe        = 1'b1;
        busy       = 1'b0;
        ack        = 1'b0;
        a_drive_en = 1'b0;
        case (state)
            TURN: begin
                busy       = 1'b1;
                a_drive_en = dirReg;
            end
            SETTLE: begin
                busy       = 1'b1;
                _oe        = 1'b0;
                a_drive_en = dirReg;
            end
            DONE: begin
                busy       = 1'b1;
                _oe        = 1'b0;
                ack        = 1'b1;
                a_drive_en = dirReg;
            end
            RELEASE: begin
                busy       = 1'b1;
                a_drive_en = dirReg;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign dir     = dirReg;
    assign a_drive = latchedWdata;
    assign rdata   = rdataReg;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// tb/tb_bus_xfer_ctrl.sv - self-checking bench for bus_xfer_ctrl
module tb_bus_xfer_ctrl;

    localparam int TurnCycles   = 2;
    localparam int SettleCycles = 2;

    logic       clk = 1'b0;
    logic       rstN;
    logic       req;
    logic       wr;
    logic [7:0] wdata;
    logic [7:0] aIn;
    logic [7:0] aDrive;
    logic       aDriveEn;
    logic       dir;
    logic       oeN;
    logic       busy;
    logic       ack;
    logic [7:0] rdata;

    int vectors     = 0;
    int miscompares = 0;
    int assertFails = 0;

    // Transaction-level model state: direction of the last transfer and last read byte.
    logic       modelDir;
    logic [7:0] lastRd;

    typedef struct {
        logic       wr;
        logic [7:0] wdata;
        logic [7:0] ain;
        int         expAck;
        int         expBusy;
        logic [7:0] expRd;
    } vec_t;

    vec_t tbl[7];

    int  heldAcks;
    int  lastAckAt;
    logic idleSeen;
    logic found;
    logic sawAck;
    logic prevDir;
    logic prevOe;

    always #5 clk = ~clk;

    bus_xfer_ctrl #(
        .TURN_CYCLES  (TurnCycles),
        .SETTLE_CYCLES(SettleCycles)
    ) dut (
        .clk       (clk),
        ._reset    (rstN),
        .req       (req),
        .wr        (wr),
        .wdata     (wdata),
        .a_in      (aIn),
        .a_drive   (aDrive),
        .a_drive_en(aDriveEn),
        .dir       (dir),
        ._oe       (oeN),
        .busy      (busy),
        .ack       (ack),
        .rdata     (rdata)
    );

    // Safety monitor: dir moves only with _oe high on both sides of the edge; driver never on with dir=0.
    always @(negedge clk or negedge rstN) begin
        if (!rstN) begin
            prevDir <= 1'b0;
            prevOe  <= 1'b1;
        end else begin
            if (dir !== prevDir && (prevOe !== 1'b1 || oeN !== 1'b1)) begin
                $display("FAIL dir_change_with_oe_low: dir %0b->%0b, oe_n before %0b after %0b, required oe_n 1/1",
                         prevDir, dir, prevOe, oeN);
                assertFails <= assertFails + 1;
            end
            if (aDriveEn === 1'b1 && dir !== 1'b1) begin
                $display("FAIL drive_en_while_dir0: a_drive_en %0b dir %0b, required a_drive_en 0", aDriveEn, dir);
                assertFails <= assertFails + 1;
            end
            prevDir <= dir;
            prevOe  <= oeN;
        end
    end

    task automatic check1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic checkN(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; issues one request and watches it to completion.
    task automatic runXfer(input logic w, input logic [7:0] wd, input logic [7:0] ain,
                           input int expAck, input int expBusy, input logic [7:0] expRd);
        int         ackAt;
        int         busyN;
        int         ackN;
        int         oeLowN;
        logic       driveOk;
        logic       finished;
        logic [7:0] rdAtAck;
        ackAt    = 0;
        busyN    = 0;
        ackN     = 0;
        oeLowN   = 0;
        driveOk  = 1'b1;
        finished = 1'b0;
        rdAtAck  = 8'd0;
        req   = 1'b1;
        wr    = w;
        wdata = wd;
        aIn   = ain;
        @(posedge clk);
        @(negedge clk);
        req   = 1'b0;
        wr    = ~w;
        wdata = ~wd;
        for (int c = 1; c <= 600 && !finished; c++) begin
            if (busy !== 1'b1) begin
                finished = 1'b1;
            end else begin
                busyN++;
                if (oeN === 1'b0) oeLowN++;
                if (ack === 1'b1) begin
                    ackN++;
                    ackAt   = c;
                    rdAtAck = rdata;
                    aIn     = ~ain;
                end
                if (dir !== w || aDriveEn !== w || (w && aDrive !== wd)) driveOk = 1'b0;
                @(negedge clk);
            end
        end
        check1("xfer_done", finished, 1'b1);
        checkN("ack_latency", ackAt, expAck);
        checkN("busy_cycles", busyN, expBusy);
        checkN("ack_pulses", ackN, 1);
        checkN("oe_low_cycles", oeLowN, SettleCycles + 1);
        check1("drive_dir_hold", driveOk, 1'b1);
        check8("rdata_at_ack", rdAtAck, expRd);
        check8("rdata_hold", rdata, expRd);
        check1("dir_retained", dir, w);
        check1("drive_en_idle", aDriveEn, 1'b0);
        check1("ack_idle", ack, 1'b0);
    endtask

    // Expected timing from the rules: turnaround is long only on a direction flip.
    task automatic modelXfer(input logic w, input logic [7:0] wd, input logic [7:0] ain);
        int         t;
        logic [7:0] rd;
        t  = (w != modelDir) ? TurnCycles : 1;
        rd = w ? lastRd : ain;
        runXfer(w, wd, ain, t + SettleCycles + 1, t + SettleCycles + 2, rd);
        modelDir = w;
        lastRd   = rd;
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'hA5, 8'h00, 5, 6, 8'h00};
        tbl[1] = '{1'b1, 8'h3C, 8'h00, 4, 5, 8'h00};
        tbl[2] = '{1'b0, 8'h00, 8'h5A, 5, 6, 8'h5A};
        tbl[3] = '{1'b0, 8'hFF, 8'hC3, 4, 5, 8'hC3};
        tbl[4] = '{1'b1, 8'h0F, 8'h11, 5, 6, 8'hC3};
        tbl[5] = '{1'b1, 8'hF0, 8'h22, 4, 5, 8'hC3};
        tbl[6] = '{1'b0, 8'h81, 8'h77, 5, 6, 8'h77};

        rstN  = 1'b0;
        req   = 1'b0;
        wr    = 1'b0;
        wdata = 8'd0;
        aIn   = 8'd0;
        #1;
        check1("reset_oe_n", oeN, 1'b1);
        check1("reset_dir", dir, 1'b0);
        check1("reset_drive_en", aDriveEn, 1'b0);
        check8("reset_drive", aDrive, 8'h00);
        check1("reset_busy", busy, 1'b0);
        check1("reset_ack", ack, 1'b0);
        check8("reset_rdata", rdata, 8'h00);

        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;

        // Directed table; the first request is sampled on the first edge after reset release.
        for (int i = 0; i < 7; i++) begin
            runXfer(tbl[i].wr, tbl[i].wdata, tbl[i].ain, tbl[i].expAck, tbl[i].expBusy, tbl[i].expRd);
        end
        modelDir = 1'b0;
        lastRd   = 8'h77;

        // Reset pulse in the middle of SETTLE of a write.
        req   = 1'b1;
        wr    = 1'b1;
        wdata = 8'h11;
        @(posedge clk);
        @(negedge clk);
        req   = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (oeN === 1'b0) found = 1'b1;
            else @(negedge clk);
        end
        check1("reached_settle", found, 1'b1);
        check1("settle_dir", dir, 1'b1);
        rstN = 1'b0;
        #1;
        check1("midreset_oe_n", oeN, 1'b1);
        check1("midreset_dir", dir, 1'b0);
        check1("midreset_drive_en", aDriveEn, 1'b0);
        check1("midreset_busy", busy, 1'b0);
        check1("midreset_ack", ack, 1'b0);
        check8("midreset_rdata", rdata, 8'h00);
        sawAck = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ack !== 1'b0) sawAck = 1'b1;
        end
        check1("no_ack_in_reset", sawAck, 1'b0);
        rstN     = 1'b1;
        modelDir = 1'b0;
        lastRd   = 8'h00;
        modelXfer(1'b1, 8'h99, 8'h00);

        // req held high across three transfers.
        req       = 1'b1;
        wr        = 1'b1;
        wdata     = 8'h42;
        heldAcks  = 0;
        lastAckAt = 0;
        idleSeen  = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy === 1'b0) idleSeen = 1'b1;
            if (ack === 1'b1) begin
                heldAcks++;
                if (heldAcks > 1) begin
                    check1("held_idle_gap", idleSeen, 1'b1);
                    checkN("held_ack_spacing", c - lastAckAt, 6);
                end
                lastAckAt = c;
                idleSeen  = 1'b0;
                if (heldAcks == 3) req = 1'b0;
            end
        end
        checkN("held_ack_count", heldAcks, 3);
        check1("held_busy_end", busy, 1'b0);
        modelDir = 1'b1;

        // Randomized transfers against the model.
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) begin
                wr    = 1'($urandom_range(0, 1));
                wdata = 8'($urandom);
                @(negedge clk);
            end
            modelXfer(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        end

        checkN("safety_monitor", assertFails, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bus_xfer_ctrl.md
BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

Interface
- REQ-001 The block SHALL have parameter TURN_CYCLES, default 2: cycles `_oe` stays high after a direction change before enabling; legal range 1..255.
- REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 2: cycles `_oe` stays low before the transfer completes; legal range 1..255. This covers the transceiver's ~16ns propagation.
- REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: `clk` input 1 (rising-edge clock) and `_reset` input 1 (asynchronous active-low reset).
- REQ-004 The block SHALL have the following ports (name, direction, width, meaning):
  - `req` input 1: transfer request, level, sampled in IDLE only.
  - `wr` input 1: 1 = write (A->B), 0 = read (B->A); sampled with `req`.
  - `wdata` input 8: write data, sampled with `req`.
  - `a_in` input 8: sampled value of the A-side bus.
  - `a_drive` output 8: value this block drives onto the A side.
  - `a_drive_en` output 1: enable for the A-side tri-state driver.
  - `dir` output 1: transceiver direction, 1 = A->B.
  - `_oe` output 1: transceiver output enable, active low.
  - `busy` output 1: high in every non-IDLE state.
  - `ack` output 1: one-cycle completion pulse.
  - `rdata` output 8: captured read data.

Function
- REQ-005 The block SHALL implement FSM states IDLE, TURN, SETTLE, DONE, RELEASE, with an 8-bit cycle counter.
- REQ-006 In IDLE with `req`=1 at a clock edge, the block SHALL latch `wr` and `wdata` and enter TURN; `req` SHALL be ignored in all other states.
- REQ-007 In TURN, the block SHALL:
  - drive `_oe`=1, `dir`=latched `wr`, `a_drive_en`=latched `wr`, `a_drive`=latched `wdata`;
  - stay TURN_CYCLES cycles if `dir` changed value on entry, otherwise exactly 1 cycle.
- REQ-008 In SETTLE, the block SHALL drive `_oe`=0 for SETTLE_CYCLES cycles, holding `dir`, `a_drive_en` and `a_drive`.
- REQ-009 In DONE, the block SHALL drive `_oe`=0 and `ack`=1 for exactly 1 cycle; on a read, `rdata` SHALL load `a_in` at the edge entering DONE.
- REQ-010 In RELEASE, the block SHALL drive `_oe`=1 and hold `a_drive_en` for 1 cycle, then enter IDLE with `a_drive_en`=0.
- REQ-011 The block SHALL change `dir` only on edges where `_oe` is already 1 in the current cycle and will remain 1 in the next.
- REQ-012 The block SHALL never assert `a_drive_en`=1 while `dir`=0.
- REQ-013 `a_drive_en` and `_oe`=0 SHALL never both be asserted while `dir`=0, so no A-side contention occurs.
- REQ-014 Latency: `ack` SHALL rise T+S+1 cycles after the accepting edge, where T = TURN_CYCLES (direction changed) or 1 (unchanged) and S = SETTLE_CYCLES.
- REQ-015 `busy` SHALL be high for exactly T+S+2 cycles per transfer.
- REQ-016 `req` held high continuously SHALL start a new transfer on the first IDLE edge after RELEASE; transfers are never pipelined or overlapped.
- REQ-017 `dir` SHALL retain its last value in IDLE; `rdata` SHALL hold until the next read's DONE.
- REQ-018 A `wdata` or `wr` change after acceptance SHALL have no effect on the current transfer.

Reset
- REQ-019 `_reset`=0 SHALL immediately, without a clock, force:
  - state IDLE, counter 0;
  - `_oe`=1, `dir`=0, `a_drive_en`=0, `a_drive`=0;
  - `busy`=0, `ack`=0, `rdata`=0.
- REQ-020 Reset asserted mid-transfer SHALL abort it with no `ack`; the first transfer after release behaves per REQ-007 relative to `dir`=0.
- REQ-021 Deassertion of `_reset` SHALL take effect at the next rising edge, and a `req` sampled at that edge SHALL be accepted.

Verification (TURN_CYCLES=2, SETTLE_CYCLES=2, 10ns clock)
- REQ-022 After reset, write `wdata`=8'hA5:
  - `dir` rises while `_oe`=1;
  - `_oe` low for cycles 3-5;
  - `ack` at cycle 5;
  - `a_drive`=8'hA5 with `a_drive_en`=1 throughout;
  - `busy` high 6 cycles.
- REQ-023 A second back-to-back write, 8'h3C (dir unchanged), SHALL give TURN 1 cycle and `ack` 4 cycles after acceptance.
- REQ-024 A read after a write, with `a_in`=8'h5A during SETTLE, SHALL:
  - make `dir` fall only while `_oe`=1;
  - keep `a_drive_en`=0 whenever `dir`=0;
  - give `rdata`=8'h5A at `ack`, with `ack` 5 cycles after acceptance.
- REQ-025 Pulsing `_reset` low during SETTLE SHALL give `_oe`=1, `dir`=0, `a_drive_en`=0 before the next edge, with no `ack`; the next request SHALL complete normally.
- REQ-026 With `req` held high for 3 transfers, exactly 3 `ack` pulses SHALL occur, each separated by at least one IDLE cycle.
- REQ-027 Throughout all scenarios, a bench assertion SHALL check that `dir` never changes while `_oe`=0 and that `a_drive_en` is never 1 while `dir`=0.
